// File: rtl/apb_master.sv
// APB3 requester-to-bus master: IDLE -> SETUP -> ACCESS per transfer, registered one-cycle response.
// Optional ACCESS-phase timeout compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   complete;
    logic   abort;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] to_cnt;

    // Abort on the edge the wait count would reach TIMEOUT; PREADY=1 on that edge still completes.
    assign abort = (state == ACCESS) && !PREADY && (to_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    assign accept   = cmd_valid && cmd_ready;
    assign complete = (state == ACCESS) && PREADY;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || abort) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= complete || abort;
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                if (cmd_write) begin
                    PWDATA <= cmd_wdata;
                end
            end
            if (complete) begin
                rsp_err   <= PSLVERR;
                rsp_rdata <= PWRITE ? '0 : PRDATA;
            end else if (abort) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule
